// File: rtl/serial_frame_receiver.sv
// 8N1 serial receiver: synchronizes RX, samples each bit at its centre and
// presents the byte on DATA with a one-cycle VALID (or FRAME_ERR) pulse.
module serial_frame_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_RECOVER
    } state_t;

    state_t        state, state_next;
    logic          sync1, rx_s;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    idx, idx_next;
    logic [7:0]    shreg, shreg_next;
    logic [7:0]    data_next;
    logic          valid_next, ferr_next;

    // Both synchronizer flops reset to the idle (high) line level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= RX;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shreg     <= shreg_next;
            DATA      <= data_next;
            VALID     <= valid_next;
            FRAME_ERR <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        data_next  = DATA;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    cnt_next   = '0;
                end
            end
            ST_START: begin
                // A start bit that is gone by mid-bit was a glitch.
                if (cnt == HALF_LAST) begin
                    if (!rx_s) begin
                        state_next = ST_DATA;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    shreg_next = {rx_s, shreg[7:1]};
                    cnt_next   = '0;
                    idx_next   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shreg;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = ST_RECOVER;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_RECOVER: begin
                // Wait out a held-low (break) line before looking for a start.
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign BUSY = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Receive side of the team's 8N1 asynchronous serial link: samples a single-wire line, recovers start, 8 data bits (LSB first) and stop, and presents each byte as a parallel word with a one-cycle strobe. It sits between an external RX pin and byte-oriented logic. It is built from synchronous-reset flip-flops: a two-flop input synchronizer, a bit-time counter, a shift register and a small FSM.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and ≥ 4.
- CLK  input  1  rising-edge clock.
- RST  input  1  reset; synchronous, active-high.
- RX  input  1  asynchronous serial line; idles high.
- DATA  output  8  last correctly framed byte; holds until the next good frame.
- VALID  output  1  one-cycle pulse; DATA updated in the same cycle.
- FRAME_ERR  output  1  one-cycle pulse; stop bit sampled low.
- BUSY  output  1  high in START, DATA and STOP.

## Operation
- Synchronizer: RX passes through two flops, sync1 then rx_s. Both reset to 1. The FSM sees only rx_s.
- Counter: cnt has width $clog2(CLKS_PER_BIT). Bit index: 3 bits. Shift register: 8 bits.
- Definitions: H = CLKS_PER_BIT/2; N = CLKS_PER_BIT.
- IDLE:
  - rx_s==0 → START, cnt=0.
- START:
  - cnt increments each cycle.
  - When cnt==H-1, sample rx_s.
  - rx_s==0 → DATA, cnt=0, idx=0.
  - rx_s==1 → IDLE. This is a glitch: no output pulse.
- DATA:
  - When cnt==N-1, shift rx_s in at bit 7 (the shift register shifts right, so data arrives LSB first), cnt=0, idx++.
  - After the idx==7 sample → STOP.
- STOP:
  - When cnt==N-1, sample rx_s.
  - rx_s==1: DATA←shift register, VALID=1 for one cycle → IDLE.
  - rx_s==0: FRAME_ERR=1 for one cycle, DATA unchanged → RECOVER.
- RECOVER:
  - Stay until rx_s==1, then → IDLE.
  - This prevents a held-low line (break) from retriggering frames.
- VALID and FRAME_ERR are never high together.
- Reset values: DATA=8'h00, VALID=0, FRAME_ERR=0, BUSY=0, state=IDLE, cnt=0, idx=0, shift register=0.
- RST mid-frame: the next edge forces the reset values. The partial byte is discarded and no pulse is emitted.
- RST has priority over every other event in the same cycle.

## Timing
- Edges are numbered as follows:
  - E = first edge at which sync1 captures RX=0.
  - T0 = E+2, the edge at which IDLE sees rx_s==0. START becomes active after T0.
- BUSY rises after edge T0 and falls after the stop-sample edge.
- Sample edges:
  - Start confirm: T0+H.
  - Data bit k (k=0..7): T0+H+(k+1)·N.
  - Stop: T0+H+9·N.
- VALID or FRAME_ERR is high in the cycle after edge T0+H+9·N. For N=16 that is edge E+154.
- Back-to-back frames: IDLE is re-entered at stop-mid-bit. A start edge arriving N/2 cycles later is accepted, so no idle gap is required.
- Glitch tolerance: a low pulse on rx_s shorter than H cycles is rejected.
- Bit-rate mismatch tolerated: about ±4% (sampling at bit center).

## Test plan
- Good frame 0xA5, N=16:
  - Stimulus: RX held high, then 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
  - Required: DATA=8'hA5 and VALID=1 for exactly one cycle, 154 edges after E; BUSY high throughout the frame.
- Glitch:
  - Stimulus: RX low for 4 cycles, then high.
  - Required: return to IDLE after the start-confirm sample; no VALID, no FRAME_ERR; DATA unchanged.
- Framing error:
  - Stimulus: byte 0x3C with stop bit 0, then line high.
  - Required: FRAME_ERR one cycle at stop sample; DATA keeps the previous value; RECOVER→IDLE once rx_s==1; a following good 0x55 frame yields VALID and DATA=8'h55.
- Break:
  - Stimulus: RX held low for 40·N cycles.
  - Required: exactly one FRAME_ERR pulse, no VALID, BUSY low while in RECOVER; normal reception after RX returns high.
- Back-to-back:
  - Stimulus: 0x00, 0xFF, 0x81 sent with no idle bits between frames.
  - Required: three VALID pulses exactly 10·N cycles apart, carrying 8'h00, 8'hFF, 8'h81 in order.
- Reset mid-frame:
  - Stimulus: assert RST for one cycle during data bit 4 of 0xF0.
  - Required: all outputs at reset values after that edge; no pulse for the aborted frame; the next complete 0x12 frame is received correctly.
